// File: rtl/apple2_bram.sv
// apple2_bram: single-clock true dual-port block RAM with registered outputs.
// Optional reset-clear sequencer is enabled with macro APPLE2_BRAM_CLEAR_EN.
//
// Parameters:
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width in bits
//   DEPTH       number of implemented words (<= 2**ADDR_WIDTH)
//
// Ports:
//   clk_sys    sole clock, rising edge
//   reset      synchronous active-high reset
//   address_a  port A word address
//   wren_a     port A write enable
//   data_a     port A write data
//   q_a        port A registered read data
//   address_b  port B word address
//   wren_b     port B write enable
//   data_b     port B write data
//   q_b        port B registered read data
//   busy       clear sequencer active (constant 0 without APPLE2_BRAM_CLEAR_EN)
module apple2_bram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic                  wren_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic                  wren_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] q_b,
  output logic                  busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          hit_a;
  logic          hit_b;
  logic [IW-1:0] idx_a;
  logic [IW-1:0] idx_b;

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  assign hit_a = {1'b0, address_a} < (ADDR_WIDTH+1)'(DEPTH);
  assign hit_b = {1'b0, address_b} < (ADDR_WIDTH+1)'(DEPTH);
  assign idx_a = address_a[IW-1:0];
  assign idx_b = address_b[IW-1:0];

`ifdef APPLE2_BRAM_CLEAR_EN
  logic          clr;
  logic [IW-1:0] clr_cnt;

  // Busy drops on the same edge that writes the last address.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clr     <= 1'b1;
      clr_cnt <= '0;
    end else if (clr) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IW'(DEPTH-1))
        clr <= 1'b0;
    end
  end

  assign busy = clr;
`else
  assign busy = 1'b0;
`endif

  // Port B write is issued first so port A wins a same-address collision.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      q_a <= '0;
      q_b <= '0;
`ifdef APPLE2_BRAM_CLEAR_EN
    end else if (clr) begin
      q_a          <= '0;
      q_b          <= '0;
      mem[clr_cnt] <= '0;
`endif
    end else begin
      if (wren_b && hit_b)
        mem[idx_b] <= data_b;
      if (wren_a && hit_a)
        mem[idx_a] <= data_a;
      if (!hit_a)
        q_a <= '0;
      else if (wren_a)
        q_a <= data_a;
      else
        q_a <= mem[idx_a];
      if (!hit_b)
        q_b <= '0;
      else if (wren_b)
        q_b <= data_b;
      else
        q_b <= mem[idx_b];
    end
  end

endmodule

// File: tb/tb_apple2_bram.sv
// tb_apple2_bram: directed scoreboard bench for apple2_bram.
// Covers read/write, collisions, range, reset and optional clear.
module tb_apple2_bram;

`ifdef APPLE2_BRAM_CLEAR_EN
  localparam int D = 16;
`else
  localparam int D = 6656;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] address_a = '0;
  logic        wren_a = 1'b0;
  logic [7:0]  data_a = '0;
  logic [7:0]  q_a;
  logic [13:0] address_b = '0;
  logic        wren_b = 1'b0;
  logic [7:0]  data_b = '0;
  logic [7:0]  q_b;
  logic        busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    bit         ca;
    logic [7:0] ea;
    bit         cb;
    logic [7:0] eb;
  } exp_t;

  exp_t sb[$];

  apple2_bram #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(14),
    .DEPTH(D)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .address_a(address_a),
    .wren_a(wren_a),
    .data_a(data_a),
    .q_a(q_a),
    .address_b(address_b),
    .wren_b(wren_b),
    .data_b(data_b),
    .q_b(q_b),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic wa, input logic [13:0] aa,
                      input logic [7:0] da, input logic wb,
                      input logic [13:0] ab, input logic [7:0] db,
                      input string tag,
                      input bit ca, input logic [7:0] ea,
                      input bit cb, input logic [7:0] eb);
    exp_t e;
    wren_a = wa; address_a = aa; data_a = da;
    wren_b = wb; address_b = ab; data_b = db;
    e.tag = tag; e.ca = ca; e.ea = ea; e.cb = cb; e.eb = eb;
    sb.push_back(e);
    @(posedge clk_sys);
    #1;
    e = sb.pop_front();
    if (e.ca) chk({e.tag, "_qa"}, {24'd0, q_a}, {24'd0, e.ea});
    if (e.cb) chk({e.tag, "_qb"}, {24'd0, q_b}, {24'd0, e.eb});
    wren_a = 1'b0;
    wren_b = 1'b0;
  endtask

`ifdef APPLE2_BRAM_CLEAR_EN
  // Cycles from reset release until busy is observed low.
  task automatic busy_window(input string tag, input bit poke);
    int n;
    n = 0;
    if (poke) begin
      wren_a = 1'b1; address_a = 14'd7; data_a = 8'h99;
      address_b = 14'd3;
    end
    do begin
      @(posedge clk_sys);
      #1;
      n++;
      if (poke) begin
        chk({tag, "_busy_qa"}, {24'd0, q_a}, 32'd0);
        chk({tag, "_busy_qb"}, {24'd0, q_b}, 32'd0);
      end
    end while (busy && n < 64);
    wren_a = 1'b0;
    chk({tag, "_cycles"}, n, D);
  endtask
`endif

  initial begin
    @(negedge clk_sys);
    step(0, 14'd0, 8'd0, 0, 14'd0, 8'd0, "rst0", 1, 8'h00, 1, 8'h00);
    step(0, 14'd0, 8'd0, 0, 14'd0, 8'd0, "rst1", 1, 8'h00, 1, 8'h00);
`ifdef APPLE2_BRAM_CLEAR_EN
    chk("rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    busy_window("clr0", 0);
    for (int i = 0; i < D; i++)
      step(1, 14'(i), 8'(8'hC0 + i), 0, 14'd0, 8'd0, "fill",
           1, 8'(8'hC0 + i), 0, 8'd0);
    step(0, 14'd3, 8'd0, 0, 14'd12, 8'd0, "fill_rd", 1, 8'hC3, 1, 8'hCC);
    reset = 1'b1;
    step(1, 14'd4, 8'h55, 0, 14'd3, 8'd0, "rst2", 1, 8'h00, 1, 8'h00);
    step(0, 14'd4, 8'd0, 0, 14'd3, 8'd0, "rst3", 1, 8'h00, 1, 8'h00);
    reset = 1'b0;
    busy_window("clr1", 1);
    chk("clr1_busy_low", {31'd0, busy}, 32'd0);
    for (int i = 0; i < D; i++)
      step(0, 14'(i), 8'd0, 0, 14'(D-1-i), 8'd0, "clr1_rd",
           1, 8'h00, 1, 8'h00);
    for (int i = 0; i < D; i++)
      step(1, 14'(i), 8'(8'hE0 + i), 0, 14'd0, 8'd0, "fill2",
           1, 8'(8'hE0 + i), 0, 8'd0);
    reset = 1'b1;
    step(0, 14'd0, 8'd0, 0, 14'd0, 8'd0, "rst4", 1, 8'h00, 1, 8'h00);
    reset = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step(0, 14'd0, 8'd0, 0, 14'd0, 8'd0, "rst5", 1, 8'h00, 1, 8'h00);
    reset = 1'b0;
    busy_window("clr2", 0);
    for (int i = 0; i < D; i++)
      step(0, 14'(i), 8'd0, 0, 14'(D-1-i), 8'd0, "clr2_rd",
           1, 8'h00, 1, 8'h00);
`else
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    step(1, 14'h0123, 8'hA5, 0, 14'h0000, 8'd0, "wr_a5", 1, 8'hA5, 0, 8'd0);
    step(0, 14'h0123, 8'd0, 0, 14'h0123, 8'd0, "rd_a5", 1, 8'hA5, 1, 8'hA5);
    step(1, 14'h0040, 8'h11, 0, 14'h0000, 8'd0, "wr_11", 1, 8'h11, 0, 8'd0);
    step(1, 14'h0040, 8'h22, 0, 14'h0040, 8'd0, "coll", 1, 8'h22, 1, 8'h11);
    step(0, 14'h0000, 8'd0, 0, 14'h0040, 8'd0, "coll_nx", 0, 8'd0, 1, 8'h22);
    step(1, 14'h19FF, 8'h33, 1, 14'h19FF, 8'h44, "dual", 1, 8'h33, 1, 8'h44);
    step(0, 14'h19FF, 8'd0, 0, 14'h19FF, 8'd0, "dual_rd", 1, 8'h33, 1, 8'h33);
    step(1, 14'h1A00, 8'h77, 0, 14'h19FF, 8'd0, "oor_wr", 1, 8'h00, 1, 8'h33);
    step(0, 14'h0000, 8'd0, 0, 14'h1A00, 8'd0, "oor_rd", 0, 8'd0, 1, 8'h00);
    step(1, 14'h0005, 8'h66, 1, 14'h3FFF, 8'hEE, "oor_b", 1, 8'h66, 1, 8'h00);
    step(0, 14'h0005, 8'd0, 0, 14'h19FF, 8'd0, "oor_b_rd", 1, 8'h66, 1, 8'h33);
    step(1, 14'h0002, 8'h5A, 0, 14'h0000, 8'd0, "wr_5a", 1, 8'h5A, 0, 8'd0);
    reset = 1'b1;
    step(1, 14'h0002, 8'hFF, 1, 14'h0002, 8'hFE, "rst_w0", 1, 8'h00, 1, 8'h00);
    step(0, 14'h0002, 8'd0, 0, 14'h0002, 8'd0, "rst_w1", 1, 8'h00, 1, 8'h00);
    reset = 1'b0;
    step(0, 14'h0002, 8'd0, 0, 14'h0002, 8'd0, "keep_5a", 1, 8'h5A, 1, 8'h5A);
    step(0, 14'h0123, 8'd0, 0, 14'h0040, 8'd0, "keep_o", 1, 8'hA5, 1, 8'h22);
    chk("busy_off", {31'd0, busy}, 32'd0);
`endif
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
